order_ref_map: RTL and testbench

Order-reference map stage that sits directly upstream of `order_book`. It stores every resting order (locate, price, shares, side) keyed by the 64-bit order reference number carried in add messages. On delete, execute and cancel messages it looks up the referenced order, updates or frees the entry, and emits the resolved fields on the `order_book` add and delete/execute input ports. The lookup is pipelined at one message per clock, with read-after-write forwarding.

---
 rtl/order_ref_map_pkg.sv | 33 +++
 rtl/order_ref_ram.sv | 30 +++
 rtl/order_ref_map.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_order_ref_map.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_ref_map_pkg.sv
// Shared types for the order-reference map: message types, table entry layout
// and FSM states.
package pkg;

    typedef enum logic [1:0] {
        ADD     = 2'd0,
        DELETE  = 2'd1,
        EXECUTE = 2'd2,
        CANCEL  = 2'd3
    } msg_type_t;

    // The tag is held beside this struct in the RAM word because its width
    // depends on the table size.
    typedef struct packed {
        logic        valid;
        logic [15:0] locate;
        logic [31:0] price;
        logic [31:0] shares;
        logic        buy_sell;
    } map_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } map_state_t;

    localparam int ENTRY_W = $bits(map_entry_t);

    function automatic int tag_width(input int addr_bits);
        return 64 - addr_bits;
    endfunction

endpackage

// File: rtl/order_ref_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read of the address being written in the same cycle returns the old data.
module order_ref_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/order_ref_map.sv
// Order-reference map: direct-mapped table of resting orders, resolving
// delete/execute/cancel messages into book updates with a two-cycle pipeline.
module order_ref_map
    import pkg::*;
#(
    parameter int MAP_ADDR_BITS = 10
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        msgValidIn,
    input  logic [1:0]  msgTypeIn,
    input  logic [63:0] orderRefIn,
    input  logic [15:0] locateIn,
    input  logic [31:0] priceIn,
    input  logic [31:0] sharesIn,
    input  logic        buySellIn,
    output logic        readyOut,
    output logic        addValidOut,
    output logic [15:0] locateOut,
    output logic [31:0] priceOut,
    output logic [31:0] sharesOut,
    output logic        buySellOut,
    output logic        delExecValidOut,
    output logic [15:0] mapLocateOut,
    output logic [31:0] mapPriceOut,
    output logic [31:0] mapSharesOut,
    output logic        mapBuySellOut,
    output logic        missOut,
    output logic        collisionOut,
    output logic        dbgStateOut
);

    localparam int TAG_W  = tag_width(MAP_ADDR_BITS);
    localparam int WORD_W = TAG_W + ENTRY_W;
    localparam logic [MAP_ADDR_BITS:0] CNT_ONE = 1;

    // Handshake: a message is taken on any clock edge where msgValidIn and
    // readyOut are both 1; there is no back-pressure once readyOut is high.

    map_state_t               state_q;
    logic [MAP_ADDR_BITS:0]   init_cnt_q;
    logic                     ready_q;
    logic                     accept;
    logic                     init_we;

    logic                     s1_valid_q;
    msg_type_t                s1_type_q;
    logic [MAP_ADDR_BITS-1:0] s1_idx_q;
    logic [TAG_W-1:0]         s1_tag_q;
    logic [15:0]              s1_locate_q;
    logic [31:0]              s1_price_q;
    logic [31:0]              s1_shares_q;
    logic                     s1_buy_sell_q;

    logic                     fwd_valid_q;
    logic [MAP_ADDR_BITS-1:0] fwd_idx_q;
    logic [WORD_W-1:0]        fwd_word_q;

    logic [WORD_W-1:0]        ram_rdata;
    logic [WORD_W-1:0]        cur_word;
    logic [TAG_W-1:0]         cur_tag;
    map_entry_t               cur;
    logic                     hit;
    logic [31:0]              removed;
    logic [31:0]              remaining;

    logic                     s1_we;
    logic [TAG_W-1:0]         new_tag;
    map_entry_t               new_entry;
    logic [WORD_W-1:0]        wr_word;
    logic                     add_d;
    logic                     del_d;
    logic                     miss_d;
    logic                     coll_d;
    logic [31:0]              map_shares_d;

    logic                     ram_we;
    logic [MAP_ADDR_BITS-1:0] ram_waddr;
    logic [WORD_W-1:0]        ram_wdata;

    logic                     add_valid_q;
    logic [15:0]              locate_q;
    logic [31:0]              price_q;
    logic [31:0]              shares_q;
    logic                     buy_sell_q;
    logic                     del_valid_q;
    logic [15:0]              map_locate_q;
    logic [31:0]              map_price_q;
    logic [31:0]              map_shares_q;
    logic                     map_buy_sell_q;
    logic                     miss_q;
    logic                     coll_q;

    assign accept  = msgValidIn && ready_q;
    assign init_we = (state_q == ST_INIT) && !init_cnt_q[MAP_ADDR_BITS];

    // The sweep writes one index per cycle; the cycle after the last write
    // switches to RUN.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!init_cnt_q[MAP_ADDR_BITS]) begin
                        init_cnt_q <= init_cnt_q + CNT_ONE;
                    end else begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            s1_valid_q    <= 1'b0;
            s1_type_q     <= ADD;
            s1_idx_q      <= '0;
            s1_tag_q      <= '0;
            s1_locate_q   <= '0;
            s1_price_q    <= '0;
            s1_shares_q   <= '0;
            s1_buy_sell_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_type_q     <= msg_type_t'(msgTypeIn);
                s1_idx_q      <= orderRefIn[MAP_ADDR_BITS-1:0];
                s1_tag_q      <= orderRefIn[63:MAP_ADDR_BITS];
                s1_locate_q   <= locateIn;
                s1_price_q    <= priceIn;
                s1_shares_q   <= sharesIn;
                s1_buy_sell_q <= buySellIn;
            end
        end
    end

    // The RAM read for this message was issued in the same edge as the
    // previous message's write, so that write is invisible here unless forwarded.
    always_comb begin
        cur_word  = (fwd_valid_q && (fwd_idx_q == s1_idx_q)) ? fwd_word_q : ram_rdata;
        cur_tag   = cur_word[WORD_W-1 -: TAG_W];
        cur       = map_entry_t'(cur_word[ENTRY_W-1:0]);
        hit       = cur.valid && (cur_tag == s1_tag_q);
        removed   = (s1_shares_q < cur.shares) ? s1_shares_q : cur.shares;
        remaining = cur.shares - removed;

        s1_we        = 1'b0;
        new_tag      = cur_tag;
        new_entry    = cur;
        add_d        = 1'b0;
        del_d        = 1'b0;
        miss_d       = 1'b0;
        coll_d       = 1'b0;
        map_shares_d = cur.shares;

        if (s1_valid_q) begin
            case (s1_type_q)
                ADD: begin
                    s1_we              = 1'b1;
                    new_tag            = s1_tag_q;
                    new_entry.valid    = 1'b1;
                    new_entry.locate   = s1_locate_q;
                    new_entry.price    = s1_price_q;
                    new_entry.shares   = s1_shares_q;
                    new_entry.buy_sell = s1_buy_sell_q;
                    add_d              = 1'b1;
                    coll_d             = cur.valid && (cur_tag != s1_tag_q);
                end
                DELETE: begin
                    if (hit) begin
                        s1_we           = 1'b1;
                        new_entry.valid = 1'b0;
                        del_d           = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
                default: begin
                    if (s1_shares_q != 32'd0) begin
                        if (hit) begin
                            s1_we            = 1'b1;
                            new_entry.shares = remaining;
                            new_entry.valid  = (remaining != 32'd0);
                            del_d            = 1'b1;
                            map_shares_d     = removed;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
            endcase
        end
        wr_word = {new_tag, new_entry};
    end

    assign ram_we    = init_we || s1_we;
    assign ram_waddr = init_we ? init_cnt_q[MAP_ADDR_BITS-1:0] : s1_idx_q;
    assign ram_wdata = init_we ? '0 : wr_word;

    order_ref_ram #(
        .ADDR_W (MAP_ADDR_BITS),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk_i   (clkIn),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (accept),
        .raddr_i (orderRefIn[MAP_ADDR_BITS-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_word_q  <= '0;
        end else begin
            fwd_valid_q <= s1_we;
            fwd_idx_q   <= s1_idx_q;
            fwd_word_q  <= wr_word;
        end
    end

    // Data outputs only move on their own pulse so the book sees stable fields.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            add_valid_q    <= 1'b0;
            locate_q       <= '0;
            price_q        <= '0;
            shares_q       <= '0;
            buy_sell_q     <= 1'b0;
            del_valid_q    <= 1'b0;
            map_locate_q   <= '0;
            map_price_q    <= '0;
            map_shares_q   <= '0;
            map_buy_sell_q <= 1'b0;
            miss_q         <= 1'b0;
            coll_q         <= 1'b0;
        end else begin
            add_valid_q <= add_d;
            del_valid_q <= del_d;
            miss_q      <= miss_d;
            coll_q      <= coll_d;
            if (add_d) begin
                locate_q   <= s1_locate_q;
                price_q    <= s1_price_q;
                shares_q   <= s1_shares_q;
                buy_sell_q <= s1_buy_sell_q;
            end
            if (del_d) begin
                map_locate_q   <= cur.locate;
                map_price_q    <= cur.price;
                map_shares_q   <= map_shares_d;
                map_buy_sell_q <= cur.buy_sell;
            end
        end
    end

    assign readyOut        = ready_q;
    assign addValidOut     = add_valid_q;
    assign locateOut       = locate_q;
    assign priceOut        = price_q;
    assign sharesOut       = shares_q;
    assign buySellOut      = buy_sell_q;
    assign delExecValidOut = del_valid_q;
    assign mapLocateOut    = map_locate_q;
    assign mapPriceOut     = map_price_q;
    assign mapSharesOut    = map_shares_q;
    assign mapBuySellOut   = map_buy_sell_q;
    assign missOut         = miss_q;
    assign collisionOut    = coll_q;
    assign dbgStateOut     = state_q;

endmodule

// File: tb/tb_order_ref_map.sv
// Randomized and directed bench for order_ref_map against a serialised
// table model of the order map.
module tb_order_ref_map;
    import pkg::*;

    localparam int AB   = 4;
    localparam int NENT = 16;

    logic        clk = 1'b0;
    logic        rstIn;
    logic        msgValidIn;
    logic [1:0]  msgTypeIn;
    logic [63:0] orderRefIn;
    logic [15:0] locateIn;
    logic [31:0] priceIn;
    logic [31:0] sharesIn;
    logic        buySellIn;
    logic        readyOut, addValidOut, buySellOut, delExecValidOut, mapBuySellOut;
    logic        missOut, collisionOut, dbgStateOut;
    logic [15:0] locateOut, mapLocateOut;
    logic [31:0] priceOut, sharesOut, mapPriceOut, mapSharesOut;

    always #5 clk = ~clk;

    order_ref_map #(.MAP_ADDR_BITS(AB)) dut (
        .clkIn           (clk),
        .rstIn           (rstIn),
        .msgValidIn      (msgValidIn),
        .msgTypeIn       (msgTypeIn),
        .orderRefIn      (orderRefIn),
        .locateIn        (locateIn),
        .priceIn         (priceIn),
        .sharesIn        (sharesIn),
        .buySellIn       (buySellIn),
        .readyOut        (readyOut),
        .addValidOut     (addValidOut),
        .locateOut       (locateOut),
        .priceOut        (priceOut),
        .sharesOut       (sharesOut),
        .buySellOut      (buySellOut),
        .delExecValidOut (delExecValidOut),
        .mapLocateOut    (mapLocateOut),
        .mapPriceOut     (mapPriceOut),
        .mapSharesOut    (mapSharesOut),
        .mapBuySellOut   (mapBuySellOut),
        .missOut         (missOut),
        .collisionOut    (collisionOut),
        .dbgStateOut     (dbgStateOut)
    );

    typedef struct packed {
        logic        add;
        logic        del;
        logic        miss;
        logic        coll;
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] shares;
        logic        bs;
        logic [15:0] mloc;
        logic [31:0] mprice;
        logic [31:0] mshares;
        logic        mbs;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        held;
    logic        tv[NENT];
    logic [63:0] tref[NENT];
    logic [15:0] tloc[NENT];
    logic [31:0] tprice[NENT];
    logic [31:0] tsh[NENT];
    logic        tbs[NENT];
    int          since_rst;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("add_valid", addValidOut, e.add);
        chk("del_valid", delExecValidOut, e.del);
        chk("miss", missOut, e.miss);
        chk("collision", collisionOut, e.coll);
        chk("locate", locateOut, e.loc);
        chk("price", priceOut, e.price);
        chk("shares", sharesOut, e.shares);
        chk("buy_sell", buySellOut, e.bs);
        chk("map_locate", mapLocateOut, e.mloc);
        chk("map_price", mapPriceOut, e.mprice);
        chk("map_shares", mapSharesOut, e.mshares);
        chk("map_buy_sell", mapBuySellOut, e.mbs);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NENT; i++) begin
            tv[i] = 1'b0;
        end
        held = '0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    // Applies one message to the table in arrival order and queues the
    // outputs it must produce two cycles later.
    task automatic model(input bit acc, input msg_type_t t, input logic [63:0] r,
                         input logic [15:0] loc, input logic [31:0] pr,
                         input logic [31:0] sh, input logic bs);
        exp_t        e;
        int          i;
        logic [31:0] rem;
        e = held;
        if (acc) begin
            i = int'(r[AB-1:0]);
            if (t == ADD) begin
                e.coll    = tv[i] && (tref[i] != r);
                tv[i]     = 1'b1;
                tref[i]   = r;
                tloc[i]   = loc;
                tprice[i] = pr;
                tsh[i]    = sh;
                tbs[i]    = bs;
                e.add     = 1'b1;
                e.loc     = loc;
                e.price   = pr;
                e.shares  = sh;
                e.bs      = bs;
            end else if (t != DELETE && sh == 0) begin
                e.miss = 1'b0;
            end else if (tv[i] && tref[i] == r) begin
                rem       = (t == DELETE || sh >= tsh[i]) ? tsh[i] : sh;
                e.del     = 1'b1;
                e.mloc    = tloc[i];
                e.mprice  = tprice[i];
                e.mshares = rem;
                e.mbs     = tbs[i];
                tsh[i]    = tsh[i] - rem;
                if (t == DELETE || tsh[i] == 0) tv[i] = 1'b0;
            end else begin
                e.miss = 1'b1;
            end
        end
        exp_q.push_back(e);
        held      = e;
        held.add  = 1'b0;
        held.del  = 1'b0;
        held.miss = 1'b0;
        held.coll = 1'b0;
    endtask

    task automatic cycle(input bit v, input msg_type_t t, input logic [63:0] r,
                         input logic [15:0] loc, input logic [31:0] pr,
                         input logic [31:0] sh, input logic bs);
        exp_t e;
        @(negedge clk);
        since_rst++;
        chk("ready", readyOut, since_rst >= 17);
        e = exp_q.pop_front();
        check_out(e);
        msgValidIn = v;
        msgTypeIn  = t;
        orderRefIn = r;
        locateIn   = loc;
        priceIn    = pr;
        sharesIn   = sh;
        buySellIn  = bs;
        model(v && since_rst >= 17, t, r, loc, pr, sh, bs);
    endtask

    task automatic idle();
        cycle(1'b0, ADD, 64'd0, 16'd0, 32'd0, 32'd0, 1'b0);
    endtask
    task automatic add(input logic [63:0] r, input logic [15:0] loc, input logic [31:0] pr,
                       input logic [31:0] sh, input logic bs);
        cycle(1'b1, ADD, r, loc, pr, sh, bs);
    endtask
    task automatic del(input logic [63:0] r);
        cycle(1'b1, DELETE, r, 16'd0, 32'd0, 32'd0, 1'b0);
    endtask
    task automatic exe(input logic [63:0] r, input logic [31:0] sh);
        cycle(1'b1, EXECUTE, r, 16'd0, 32'd0, sh, 1'b0);
    endtask
    task automatic can(input logic [63:0] r, input logic [31:0] sh);
        cycle(1'b1, CANCEL, r, 16'd0, 32'd0, sh, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstIn      = 1'b0;
        msgValidIn = 1'b0;
        @(negedge clk);
        chk("rst_ready", readyOut, 1'b0);
        chk("rst_add_valid", addValidOut, 1'b0);
        chk("rst_del_valid", delExecValidOut, 1'b0);
        chk("rst_miss", missOut, 1'b0);
        chk("rst_collision", collisionOut, 1'b0);
        chk("rst_map_shares", mapSharesOut, 32'd0);
        chk("rst_shares", sharesOut, 32'd0);
        @(negedge clk);
        rstIn     = 1'b1;
        since_rst = 0;
        model_clear();
    endtask

    task automatic rand_msgs(input int n);
        logic [59:0] tags[3];
        msg_type_t   t;
        logic [63:0] r;
        int          k;
        tags[0] = 60'd0;
        tags[1] = 60'd1;
        tags[2] = 60'hFEDCBA987654321;
        for (int j = 0; j < n; j++) begin
            k = $urandom_range(0, 99);
            t = (k < 35) ? ADD : (k < 55) ? DELETE : (k < 80) ? EXECUTE : CANCEL;
            r = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 7))};
            cycle($urandom_range(0, 9) != 0, t, r, 16'($urandom), $urandom,
                  (t == ADD) ? 32'($urandom_range(1, 200)) : 32'($urandom_range(0, 150)),
                  1'($urandom));
        end
    endtask

    initial begin
        rstIn      = 1'b0;
        msgValidIn = 1'b0;
        msgTypeIn  = 2'd0;
        orderRefIn = '0;
        locateIn   = '0;
        priceIn    = '0;
        sharesIn   = '0;
        buySellIn  = 1'b0;
        since_rst  = 0;
        model_clear();
        do_reset();

        for (int i = 0; i < 17; i++) begin
            if (i == 2) add(64'h77, 16'd1, 32'd5, 32'd9, 1'b1);
            else idle();
        end
        del(64'h77);

        add(64'h25, 16'd7, 32'd10000, 32'd300, 1'b1);
        del(64'h25);
        del(64'h25);

        add(64'h31, 16'd3, 32'd2000, 32'd100, 1'b0);
        exe(64'h31, 32'd40);
        exe(64'h31, 32'd100);
        can(64'h31, 32'd10);

        add(64'h42, 16'd9, 32'd777, 32'd50, 1'b1);
        can(64'h42, 32'd20);
        can(64'h42, 32'd20);
        del(64'h42);

        add(64'h05, 16'd11, 32'd123, 32'd10, 1'b0);
        add(64'h15, 16'd12, 32'd456, 32'd20, 1'b1);
        del(64'h05);

        add(64'h09, 16'd4, 32'd99, 32'd30, 1'b1);
        exe(64'h09, 32'd0);
        can(64'h0A, 32'd0);
        exe(64'h09, 32'd30);
        idle();
        idle();

        rand_msgs(600);

        add(64'h60, 16'd1, 32'd1, 32'd1, 1'b1);
        add(64'h61, 16'd2, 32'd2, 32'd2, 1'b0);
        del(64'h15);
        do_reset();
        for (int i = 0; i < 17; i++) idle();
        del(64'h15);
        del(64'h60);
        can(64'h61, 32'd1);
        rand_msgs(200);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
